// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART receiver: 16x oversampled 8N1 deframer with rda/framing/overrun flags
// Optional even-parity bit and sticky parity_err when RX_PARITY_EN is defined.
module spart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 read,
  output logic [DATA_BITS-1:0] rx_out,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [DATA_BITS-1:0]   rx_out_q;
  logic                   rda_q, framing_q, overrun_q;
  logic                   stop_tick, done_good, done_bad;

  // Synchroniser resets to idle-high so reset release never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end
  assign rxd_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_q;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (rx_enable) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == HALF_M1) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (tick_q == FULL_M1) begin
            tick_d    = '0;
            par_bad_d = rxd_s ^ (^shift_q);
            state_d   = STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stop_tick = rx_enable && (state_q == STOP) && (tick_q == FULL_M1);
    done_good = stop_tick && rxd_s;
    done_bad  = stop_tick && !rxd_s;
  end

  // A completion in the same cycle as read wins: the byte stays available and is not an overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_out_q  <= '0;
      rda_q     <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (done_good) begin
        rx_out_q <= shift_q;
        rda_q    <= 1'b1;
      end else if (read) begin
        rda_q <= 1'b0;
      end
      if (done_good && rda_q && !read) overrun_q <= 1'b1;
      else if (read)                   overrun_q <= 1'b0;
      if (done_bad)  framing_q <= 1'b1;
      else if (read) framing_q <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      if (done_good && par_bad_q) parity_q <= 1'b1;
      else if (read)              parity_q <= 1'b0;
    end
  end
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_out      = rx_out_q;
  assign rda         = rda_q;
  assign framing_err = framing_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - directed scoreboard bench for spart_rx
module tb_spart_rx;

  localparam int TICK_DIV = 10;
  localparam int BITCLK   = TICK_DIV * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_enable = 1'b0;
  logic       rxd = 1'b1;
  logic       read = 1'b0;
  logic [7:0] rx_out;
  logic       rda, framing_err, overrun, parity_err;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_enable   (rx_enable),
    .rxd         (rxd),
    .read        (read),
    .rx_out      (rx_out),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      rx_enable = 1'b1;
      @(negedge clk);
      rx_enable = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.data = d;
`ifdef RX_PARITY_EN
    e.perr = par_bit ^ (^d);
`else
    e.perr = 1'b0 & par_bit;
`endif
    if (stop_bit) exp_q.push_back(e);
    rxd = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BITCLK) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    rxd = par_bit;
    repeat (BITCLK) @(negedge clk);
`endif
    rxd = stop_bit;
    repeat (BITCLK) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * TICK_DIV) @(negedge clk);
  endtask

  task automatic check_byte(input string tag);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=empty_scoreboard expected=pending_byte", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(rx_out), 32'(e.data));
      chk({tag, "_rda"}, 32'(rda), 32'd1);
      chk({tag, "_perr"}, 32'(parity_err), 32'(e.perr));
    end
  endtask

  task automatic do_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_flags(input string tag, input logic r, input logic fe, input logic ov);
    chk({tag, "_rda"}, 32'(rda), 32'(r));
    chk({tag, "_ferr"}, 32'(framing_err), 32'(fe));
    chk({tag, "_ovr"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    // reset and idle line
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rx_out", 32'(rx_out), 32'h0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    repeat (1000) @(negedge clk);
    chk_flags("idle", 1'b0, 1'b0, 1'b0);

    // single good byte then read
    send_frame(8'h22, 1'b1, 1'b0);
    check_byte("b22");
    chk_flags("b22", 1'b1, 1'b0, 1'b0);
    do_read();
    chk("b22_read_rda", 32'(rda), 32'h0);

    // glitch shorter than half a bit
    rxd = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BITCLK) @(negedge clk);
    chk_flags("glitch", 1'b0, 1'b0, 1'b0);

    // framing error keeps old byte
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (2 * BITCLK) @(negedge clk);
    chk_flags("frame", 1'b0, 1'b1, 1'b0);
    chk("frame_rx_out", 32'(rx_out), 32'h22);
    do_read();
    chk("frame_read_ferr", 32'(framing_err), 32'h0);

    // overrun
    send_frame(8'h11, 1'b1, 1'b0);
    check_byte("b11");
    send_frame(8'h7E, 1'b1, 1'b0);
    check_byte("b7e");
    chk_flags("ovr", 1'b1, 1'b0, 1'b1);
    do_read();
    chk_flags("ovr_read", 1'b0, 1'b0, 1'b0);

    // data boundary patterns
    send_frame(8'h00, 1'b1, 1'b0);
    check_byte("b00");
    do_read();
    send_frame(8'hFF, 1'b1, 1'b0);
    check_byte("bff");
    chk_flags("bff", 1'b1, 1'b0, 1'b0);
    do_read();

`ifdef RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    check_byte("par_bad");
    do_read();
    chk("par_read", 32'(parity_err), 32'h0);
    send_frame(8'h03, 1'b1, 1'b0);
    check_byte("par_good");
    do_read();
`endif

    // reset in the middle of a frame
    rxd = 1'b0;
    repeat (BITCLK) @(negedge clk);
    rxd = 1'b1;
    repeat (BITCLK) @(negedge clk);
    rxd = 1'b0;
    repeat (BITCLK / 2) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * BITCLK) @(negedge clk);
    chk("midrst_rx_out", 32'(rx_out), 32'h0);
    chk_flags("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
